// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = STATE_W'(0),
      RUN  = STATE_W'(1),
      DONE = STATE_W'(2)
   } state_t;

   // Digit counter width: clog2 of the slice count, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder; chained DIGIT times to form the per-cycle ripple slice.
//   a, b, cin : addend bits and carry-in
//   s, co     : sum bit and carry-out
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: latches a, b, cin and adds DIGIT bits per clock, LSB first.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (result held until accepted)
//   sum, cout           : a + b + cin modulo 2^WIDTH, carry out of the top bit
//   ovf                 : carry into top bit XOR cout (SERIAL_ADDER_OVF_EN only)
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NSLICE = WIDTH / DIGIT;
   localparam int unsigned CNT_W  = cnt_width(NSLICE);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   // Reject configurations that cannot be split into whole slices.
   generate
      if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   sum_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic [DIGIT-1:0]   a_sl, b_sl, s_sl;
   logic [DIGIT:0]     c;

   // Select the current operand slice and merge the new sum slice in place.
   always_comb begin
      a_sl  = '0;
      b_sl  = '0;
      sum_d = sum;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_sl                     = a_q[i*DIGIT +: DIGIT];
            b_sl                     = b_q[i*DIGIT +: DIGIT];
            sum_d[i*DIGIT +: DIGIT]  = s_sl;
         end
      end
   end

   // Ripple chain for one slice, seeded by the carry stored from the previous slice.
   assign c[0] = carry_q;
   for (genvar k = 0; k < DIGIT; k++) begin : g_cell
      full_adder_cell u_fa (
         .a   (a_sl[k]),
         .b   (b_sl[k]),
         .cin (c[k]),
         .s   (s_sl[k]),
         .co  (c[k+1])
      );
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)       state_d = RUN;
         RUN:     if (cnt_q == LAST)  state_d = DONE;
         DONE:    if (out_ready)      state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Datapath and registered handshake flags (decoded from the next state).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               sum     <= sum_d;
               carry_q <= c[DIGIT];
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cout <= c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                  // Top cell of the last slice: carry into bit WIDTH-1 vs carry out.
                  ovf  <= c[DIGIT-1] ^ c[DIGIT];
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: DIGIT=1 and DIGIT=4 instances at WIDTH=8.
// Stimulus pushes expected results; per-instance monitors pop on out_valid && out_ready.
// ovf is connected and checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   typedef struct packed {
      logic [7:0] s;
      logic       c;
      logic       o;
   } res_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic       ci;
      res_t       r;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid, in_ready, cin, out_valid, out_ready, cout;
   logic [7:0] a, b, sum;
   logic       iv4, ir4, cin4, ov4, or4, cout4;
   logic [7:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf, ovf4;
`endif

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(or4),
      .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf4)
`endif
   );

   res_t exp_q[$], exp4_q[$];
   int   lat_q[$], lat4_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic pv = 1'b0, pv4 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic note_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
      logic [8:0] t;
      res_t r;
      t   = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      r.s = t[7:0];
      r.c = t[8];
      r.o = (x[7] == y[7]) && (t[7] != x[7]);
      return r;
   endfunction

   // Monitor, DIGIT=1 instance.
   always @(negedge clk) begin
      if (!rst_n) pv = 1'b0;
      else begin
         if (out_valid) check("ready_valid_excl", 32'(in_ready), 32'd0);
         if (out_valid && !pv) begin
            if (lat_q.size() == 0) note_fail("unexpected_result");
            else check("latency_d1", 32'(cyc - lat_q.pop_front()), 32'd8);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) note_fail("unexpected_retire");
            else begin
               res_t e;
               e = exp_q.pop_front();
               check("sum_d1", 32'(sum), 32'(e.s));
               check("cout_d1", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
               check("ovf_d1", 32'(ovf), 32'(e.o));
`endif
            end
         end
         pv = out_valid;
      end
   end

   // Monitor, DIGIT=4 instance.
   always @(negedge clk) begin
      if (!rst_n) pv4 = 1'b0;
      else begin
         if (ov4 && !pv4) begin
            if (lat4_q.size() == 0) note_fail("unexpected_result_d4");
            else check("latency_d4", 32'(cyc - lat4_q.pop_front()), 32'd2);
         end
         if (ov4 && or4) begin
            if (exp4_q.size() == 0) note_fail("unexpected_retire_d4");
            else begin
               res_t e;
               e = exp4_q.pop_front();
               check("sum_d4", 32'(sum4), 32'(e.s));
               check("cout_d4", 32'(cout4), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
               check("ovf_d4", 32'(ovf4), 32'(e.o));
`endif
            end
         end
         pv4 = ov4;
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge with in_valid still high.
   task automatic send(input vec_t v, output int acc);
      int g = 0;
      a = v.x; b = v.y; cin = v.ci; in_valid = 1'b1;
      exp_q.push_back(v.r);
      acc = -1;
      while (!in_ready && g < 200) begin @(negedge clk); g++; end
      if (!in_ready) note_fail("accept_timeout_d1");
      else begin
         acc = cyc + 1;
         lat_q.push_back(acc);
      end
      @(negedge clk);
   endtask

   task automatic send4(input vec_t v);
      int g = 0;
      a4 = v.x; b4 = v.y; cin4 = v.ci; iv4 = 1'b1;
      exp4_q.push_back(v.r);
      while (!ir4 && g < 200) begin @(negedge clk); g++; end
      if (!ir4) note_fail("accept_timeout_d4");
      else lat4_q.push_back(cyc + 1);
      @(negedge clk);
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || exp4_q.size() != 0) && g < 500) begin
         @(negedge clk); g++;
      end
      check("drain", 32'(exp_q.size() + exp4_q.size()), 32'd0);
   endtask

   vec_t dv[8];
   vec_t d4[4];
   int   acc, last_acc;

   initial begin
      in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
      iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; or4 = 1;

      //           x      y      ci     s      c     o   (hand-computed)
      dv[0] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0}};
      dv[1] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
      dv[2] = '{8'hFF, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0}};
      dv[3] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}};
      dv[4] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}};
      dv[5] = '{8'hAA, 8'h55, 1'b1, '{8'h00, 1'b1, 1'b0}};
      dv[6] = '{8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0}};
      dv[7] = '{8'hC8, 8'h64, 1'b1, '{8'h2D, 1'b1, 1'b0}};
      d4[0] = '{8'hA5, 8'h5B, 1'b1, '{8'h01, 1'b1, 1'b0}};
      d4[1] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0}};
      d4[2] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}};
      d4[3] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors, back to back.
      for (int i = 0; i < 8; i++) send(dv[i], acc);
      in_valid = 1'b0;
      drain();

      // Backpressure: hold result for 5 cycles while in_valid pulses.
      out_ready = 1'b0;
      send('{8'h5A, 8'h3C, 1'b0, '{8'h96, 1'b0, 1'b1}}, acc);
      in_valid = 1'b0;
      for (int g = 0; g < 50 && !out_valid; g++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_sum", 32'(sum), 32'h96);
         check("bp_cout", 32'(cout), 32'd0);
         in_valid = ~in_valid; a = 8'hFF; b = 8'hFF; cin = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (12) @(negedge clk);
      check("bp_no_extra", 32'(out_valid), 32'd0);
      check("bp_idle_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset in RUN cycle 3, then a fresh transaction.
      send('{8'h80, 8'h40, 1'b0, '{8'hC0, 1'b0, 1'b0}}, acc);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_cout", 32'(cout), 32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("arst_ovf", 32'(ovf), 32'd0);
`endif
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      send('{8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0}}, acc);
      in_valid = 1'b0;
      drain();

      // 1000 random operands with in_valid and out_ready held high.
      last_acc = -1;
      for (int i = 0; i < 1000; i++) begin
         vec_t v;
         v.x  = 8'($urandom);
         v.y  = 8'($urandom);
         v.ci = 1'($urandom);
         v.r  = model(v.x, v.y, v.ci);
         send(v, acc);
         if (i > 0) check("b2b_period", 32'(acc - last_acc), 32'd10);
         last_acc = acc;
      end
      in_valid = 1'b0;
      drain();

      // DIGIT=4 instance.
      for (int i = 0; i < 4; i++) send4(d4[i]);
      iv4 = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
